// File: rtl/block_ram_stream.sv
// block_ram_stream: single-clock block RAM with an independent write port,
// a burst read engine streaming through a valid/ready handshake with a
// 2-entry skid buffer, and a hardware zero-fill (clear) engine.
module block_ram_stream #(
  parameter int SIZE       = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] di,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] do_data,
  output logic                  do_valid,
  input  logic                  do_ready,
  output logic                  do_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  // Storage array and its registered read port.
  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Control and datapath registers.
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]  accept_cnt_q, accept_cnt_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                  done_q, done_d;

  // Combinational helpers.
  logic                  valid;
  logic                  pop;
  logic [2:0]            occ_after_pop;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // The head word is the oldest buffered entry; with an empty buffer it is
  // the word just returned by the array (the in-flight read).
  always_comb begin
    valid         = inflight_q | (count_q != 2'd0);
    pop           = valid & do_ready;
    head_data     = (count_q != 2'd0) ? buf0_q : rdata_q;
    head_last     = (accept_cnt_q == LEN_WIDTH'(len_q - LEN_WIDTH'(1)));
    occ_after_pop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en         = (state_q == S_READ) && (issue_cnt_q < len_q) &&
                    (occ_after_pop < 3'd2);
    raddr         = base_q + issue_cnt_q[ADDR_WIDTH-1:0];
    // The clear engine owns the array while clearing; user writes are dropped.
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else begin
      mem_we    = we;
      mem_waddr = waddr;
      mem_wdata = di;
    end
  end

  // Outputs are zero whenever no word is presented, so reset forces do=0
  // without having to reset the array read register.
  always_comb begin
    do_valid = valid;
    do_data  = valid ? head_data : '0;
    do_last  = valid & head_last;
    busy     = (state_q != S_IDLE);
    done     = done_q;
  end

  // Array write (clear engine or user) and read-first registered read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (rd_en) begin
      rdata_q <= mem[raddr];
    end
  end

  // Next-state logic: skid buffer bookkeeping, then the command/state machine.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    issue_cnt_d  = issue_cnt_q;
    accept_cnt_d = accept_cnt_q;
    clr_cnt_d    = clr_cnt_q;
    inflight_d   = rd_en;
    count_d      = count_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    done_d       = 1'b0;

    // The word returned by the array lands in the buffer unless it is
    // consumed directly in the same cycle it is presented.
    case (count_q)
      2'd0: begin
        if (inflight_q && !pop) begin
          buf0_d  = rdata_q;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (pop) begin
          if (inflight_q) begin
            buf0_d = rdata_q;
          end else begin
            count_d = 2'd0;
          end
        end else if (inflight_q) begin
          buf1_d  = rdata_q;
          count_d = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          buf0_d = buf1_q;
          if (inflight_q) begin
            buf1_d = rdata_q;
          end else begin
            count_d = 2'd1;
          end
        end
      end
    endcase

    case (state_q)
      S_IDLE: begin
        if (clr) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end else if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = S_READ;
            base_d       = base_addr;
            len_d        = len;
            issue_cnt_d  = '0;
            accept_cnt_d = '0;
            count_d      = 2'd0;
            inflight_d   = 1'b0;
          end
        end
      end
      S_READ: begin
        if (rd_en) begin
          issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
        end
        if (pop) begin
          accept_cnt_d = accept_cnt_q + LEN_WIDTH'(1);
          if (head_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == ADDR_WIDTH'(SIZE - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with asynchronous reset; aborting clears all control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      clr_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      count_q      <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      issue_cnt_q  <= issue_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_block_ram_stream.sv
// Testbench for block_ram_stream: directed scenarios plus randomized bursts
// checked against an array model of the memory contents.
module tb_block_ram_stream;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [9:0]  waddr;
  logic [7:0]  di;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len;
  logic        clr;
  logic [7:0]  do_data;
  logic        do_valid;
  logic        do_ready;
  logic        do_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [1024];
  logic [7:0] got [$];
  bit         pat [7] = '{1, 0, 0, 1, 0, 1, 1};

  block_ram_stream #(
    .SIZE(1024), .ADDR_WIDTH(10), .DATA_WIDTH(8), .LEN_WIDTH(11)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .di(di),
    .start(start), .base_addr(base_addr), .len(len), .clr(clr),
    .do_data(do_data), .do_valid(do_valid), .do_ready(do_ready),
    .do_last(do_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [9:0] a, input logic [7:0] d);
    we = 1'b1; waddr = a; di = d;
    tick();
    we = 1'b0;
    model[a] = d;
  endtask

  // Number of stream words that disagree with the model (plus a length miss).
  function automatic int stream_errors(input logic [9:0] b, input int l);
    int bad = 0;
    if (got.size() != l) bad++;
    for (int i = 0; i < l && i < got.size(); i++)
      if (got[i] !== model[(int'(b) + i) % 1024]) bad++;
    return bad;
  endfunction

  // Launches a burst and collects the transferred words into got.
  // mode 0: ready always high, 1: fixed toggle pattern, 2: random ready.
  task automatic run_burst(input logic [9:0] b, input logic [10:0] l, input int mode,
                           output int first_cyc, output int done_cyc, output int last_idx,
                           output int last_cnt, output int stab_err, output int busy_at_done);
    logic       pv;
    logic       pl;
    logic [7:0] pd;
    got.delete();
    first_cyc = -1; done_cyc = -1; last_idx = -1; last_cnt = 0; stab_err = 0;
    busy_at_done = -1; pv = 1'b0; pl = 1'b0; pd = 8'h00;
    start = 1'b1; base_addr = b; len = l; do_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      case (mode)
        0: do_ready = 1'b1;
        1: do_ready = (cyc - 1 < 7) ? pat[cyc-1] : 1'b1;
        default: do_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      if (pv && !(do_valid === 1'b1 && do_data === pd && do_last === pl)) stab_err++;
      pv = do_valid && !do_ready; pd = do_data; pl = do_last;
      if (do_valid && do_ready) begin
        got.push_back(do_data);
        if (do_last) begin last_idx = got.size() - 1; last_cnt++; end
        if (first_cyc < 0) first_cyc = cyc;
      end
      if (done) begin done_cyc = cyc; busy_at_done = int'(busy); break; end
      tick();
    end
    do_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({do_valid, do_last, busy, done} !== 4'b0000 || do_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b last=%b busy=%b done=%b do=%h expected all 0",
               do_valid, do_last, busy, done, do_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_burst();
    int fc, dc, li, lc, se, bd;
    logic [7:0] exp_w [4];
    exp_w = '{8'hF0, 8'h0F, 8'hAA, 8'h55};
    for (int i = 0; i < 4; i++) write_word(10'(i + 1), exp_w[i]);
    run_burst(10'd1, 11'd4, 0, fc, dc, li, lc, se, bd);
    checks++;
    if (got.size() !== 4) begin errors++; $display("FAIL wb_count got %0d expected 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_w[i]) begin
        errors++; $display("FAIL wb_word%0d got %h expected %h", i, got[i], exp_w[i]);
      end
    end
    checks++;
    if (fc !== 2) begin errors++; $display("FAIL wb_first_cycle got %0d expected 2", fc); end
    checks++;
    if (dc !== 6) begin errors++; $display("FAIL wb_done_cycle got %0d expected 6", dc); end
    checks++;
    if (li !== 3 || lc !== 1) begin errors++; $display("FAIL wb_last got idx %0d cnt %0d expected idx 3 cnt 1", li, lc); end
    checks++;
    if (bd !== 0) begin errors++; $display("FAIL wb_busy_at_done got %0d expected 0", bd); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL wb_done_width got %b expected 0", done); end
  endtask

  task automatic test_backpressure();
    int fc, dc, li, lc, se, bd, bad;
    run_burst(10'd1, 11'd4, 1, fc, dc, li, lc, se, bd);
    bad = stream_errors(10'd1, 4);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_data got %0d bad words expected 0", bad); end
    checks++;
    if (se !== 0) begin errors++; $display("FAIL bp_stable got %0d unstable stalls expected 0", se); end
    checks++;
    if (li !== 3 || lc !== 1) begin errors++; $display("FAIL bp_last got idx %0d cnt %0d expected idx 3 cnt 1", li, lc); end
    checks++;
    if (dc < 0) begin errors++; $display("FAIL bp_done got timeout expected done"); end
  endtask

  task automatic test_wrap();
    int fc, dc, li, lc, se, bd, bad;
    write_word(10'd1022, 8'h11);
    write_word(10'd1023, 8'h22);
    write_word(10'd0, 8'h33);
    run_burst(10'd1022, 11'd3, 0, fc, dc, li, lc, se, bd);
    bad = stream_errors(10'd1022, 3);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL wrap_data got %0d bad words expected 0", bad); end
    checks++;
    if (got.size() == 3 && got[2] !== 8'h33) begin errors++; $display("FAIL wrap_word2 got %h expected 33", got[2]); end
    checks++;
    if (li !== 2) begin errors++; $display("FAIL wrap_last got idx %0d expected 2", li); end
  endtask

  task automatic test_rdw();
    int fc, dc, li, lc, se, bd, bad, seen;
    logic [7:0] exp_old;
    write_word(10'd5, 8'h01);
    exp_old = model[5];
    do_ready = 1'b1;
    start = 1'b1; base_addr = 10'd5; len = 11'd1;
    tick();
    start = 1'b0;
    we = 1'b1; waddr = 10'd5; di = 8'h99;
    tick();
    we = 1'b0;
    model[5] = 8'h99;
    @(negedge clk);
    checks++;
    if (do_valid !== 1'b1 || do_data !== exp_old) begin
      errors++; $display("FAIL rdw_old got valid=%b do=%h expected valid=1 do=%h", do_valid, do_data, exp_old);
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    checks++;
    if (seen !== 1) begin errors++; $display("FAIL rdw_done got timeout expected done"); end
    run_burst(10'd5, 11'd1, 0, fc, dc, li, lc, se, bd);
    bad = stream_errors(10'd5, 1);
    checks++;
    if (bad !== 0 || got.size() == 0 || got[0] !== 8'h99) begin
      errors++; $display("FAIL rdw_new got %0d bad words expected 0 (value 99)", bad);
    end
  endtask

  task automatic test_back_to_back();
    int fc, dc, li, lc, se, bd, bad;
    for (int i = 0; i < 5; i++) write_word(10'(10 + i), 8'($urandom));
    for (int i = 0; i < 3; i++) write_word(10'(200 + i), 8'($urandom));
    run_burst(10'd10, 11'd5, 0, fc, dc, li, lc, se, bd);
    bad = stream_errors(10'd10, 5);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_first_data got %0d bad words expected 0", bad); end
    run_burst(10'd200, 11'd3, 0, fc, dc, li, lc, se, bd);
    bad = stream_errors(10'd200, 3);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_second_data got %0d bad words expected 0", bad); end
    checks++;
    if (fc !== 2 || dc !== 5) begin
      errors++; $display("FAIL b2b_timing got first %0d done %0d expected first 2 done 5", fc, dc);
    end
  endtask

  task automatic test_clear();
    int fc, dc, li, lc, se, bd, bad, vseen, notbusy, clr_done;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    clr_done = -1; vseen = 0; notbusy = 0;
    for (int cyc = 1; cyc < 1100; cyc++) begin
      if (cyc == 10) begin
        start = 1'b1; base_addr = 10'd0; len = 11'd4;
        we = 1'b1; waddr = 10'd3; di = 8'h77;
      end else begin
        start = 1'b0; we = 1'b0;
      end
      @(negedge clk);
      if (do_valid) vseen++;
      if (done) begin clr_done = cyc; break; end
      if (!busy) notbusy++;
      tick();
    end
    start = 1'b0; we = 1'b0;
    for (int i = 0; i < 1024; i++) model[i] = 8'h00;
    checks++;
    if (clr_done !== 1025) begin errors++; $display("FAIL clr_done_cycle got %0d expected 1025", clr_done); end
    checks++;
    if (vseen !== 0 || notbusy !== 0) begin
      errors++; $display("FAIL clr_busy got valid cycles %0d idle cycles %0d expected 0 0", vseen, notbusy);
    end
    run_burst(10'd0, 11'd1024, 2, fc, dc, li, lc, se, bd);
    bad = stream_errors(10'd0, 1024);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL clr_zero got %0d bad words expected 0", bad); end
    checks++;
    if (li !== 1023 || se !== 0) begin
      errors++; $display("FAIL clr_full_burst got last %0d unstable %0d expected 1023 0", li, se);
    end
  endtask

  task automatic test_random();
    int fc, dc, li, lc, se, bd, bad;
    int b, l;
    for (int it = 0; it < 16; it++) begin
      for (int w = 0; w < 6; w++) write_word(10'($urandom_range(0, 1023)), 8'($urandom));
      b = $urandom_range(0, 1023);
      l = $urandom_range(1, 48);
      run_burst(10'(b), 11'(l), 2, fc, dc, li, lc, se, bd);
      bad = stream_errors(10'(b), l);
      checks++;
      if (bad !== 0 || li !== l - 1 || lc !== 1 || se !== 0 || dc < 0) begin
        errors++;
        $display("FAIL rand_burst%0d base %0d len %0d got bad %0d last %0d/%0d unstable %0d done %0d expected 0 %0d/1 0 >0",
                 it, b, l, bad, li, lc, se, dc, l - 1);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int dseen, bseen;
    do_ready = 1'b1;
    start = 1'b1; base_addr = 10'd20; len = 11'd8;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({do_valid, do_last, busy, done} !== 4'b0000 || do_data !== 8'h00) begin
      errors++;
      $display("FAIL abort_outputs got valid=%b last=%b busy=%b done=%b do=%h expected all 0",
               do_valid, do_last, busy, done, do_data);
    end
    tick();
    rst_n = 1'b1;
    dseen = 0; bseen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dseen++;
      if (busy || do_valid) bseen++;
    end
    checks++;
    if (dseen !== 0 || bseen !== 0) begin
      errors++; $display("FAIL abort_quiet got done %0d busy/valid %0d expected 0 0", dseen, bseen);
    end
    tick();
    start = 1'b1; base_addr = 10'd0; len = 11'd0;
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || do_valid !== 1'b0) begin
      errors++; $display("FAIL len0_done got done=%b busy=%b valid=%b expected 1 0 0", done, busy, do_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || do_valid !== 1'b0) begin
      errors++; $display("FAIL len0_after got done=%b valid=%b expected 0 0", done, do_valid);
    end
  endtask

  initial begin
    we = 1'b0; waddr = '0; di = '0; start = 1'b0; base_addr = '0; len = '0;
    clr = 1'b0; do_ready = 1'b1; rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) model[i] = 8'h00;
    test_reset();
    test_write_burst();
    test_backpressure();
    test_wrap();
    test_rdw();
    test_back_to_back();
    test_clear();
    test_random();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_ram_stream.md
# block_ram_stream

Parametrised single-clock block RAM with an independent write port and a burst read engine. A read burst is launched by one `start` pulse and streams `len` consecutive words out through a valid/ready handshake with full backpressure. A hardware clear mode zero-fills the whole array. It is the successor to the plain `block_ram`, and holds support-vector and feature data for the cascaded SVM stages, where downstream MAC units consume words at a variable rate.

## Interface
- `SIZE`, 1024, number of words; must equal 2**`ADDR_WIDTH`
- `ADDR_WIDTH`, 10, address width
- `DATA_WIDTH`, 8, word width
- `LEN_WIDTH`, 11, burst length width; must be ≥ `ADDR_WIDTH`+1 so that `len`=`SIZE` is legal

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `we` in 1: write strobe
- `waddr` in `ADDR_WIDTH`: write address
- `di` in `DATA_WIDTH`: write data
- `start` in 1: launch a read burst; sampled only in IDLE
- `base_addr` in `ADDR_WIDTH`: first burst address; sampled with `start`
- `len` in `LEN_WIDTH`: burst length in words; sampled with `start`
- `clr` in 1: launch a zero-fill; sampled only in IDLE
- `do` out `DATA_WIDTH`: stream data
- `do_valid` out 1: `do` is valid
- `do_ready` in 1: consumer accepts `do`
- `do_last` out 1: high with the final word of a burst
- `busy` out 1: state is not IDLE
- `done` out 1: one-cycle pulse when a burst or clear completes

## Operation
- **States:** IDLE, READ, CLEAR.
- **IDLE:**
  - `clr` has priority over `start`.
  - `clr` → CLEAR.
  - `start` with `len`≠0 → READ. Latch `base_addr` and `len`; the issue counter and the accept counter are both reset to 0.
  - `start` with `len`=0 → stay in IDLE and pulse `done` on the next cycle. No data is produced.
- **Array:** synchronous read with 1-cycle latency.
- **Read-during-write to the same address:** read-first, so the old data is returned.
- **Write port:**
  - Active in IDLE and READ.
  - Ignored in CLEAR, where the array is owned by the clear engine.
- **READ issue:**
  - Address = (base + issue count) mod `SIZE`. It wraps from `SIZE`-1 to 0.
  - The output stage is a 2-entry skid buffer.
  - A read is issued in a cycle only if the issue count < `len` and (buffered words + reads in flight) < 2 after this cycle's pop.
- **Output handshake:**
  - A word transfers on `do_valid` & `do_ready`.
  - While `do_valid` is high and `do_ready` is low, `do`, `do_valid` and `do_last` are held stable.
  - `do_last` is high on word number `len`-1.
- **Burst completion:** the cycle after the `do_last` handshake, the block returns to IDLE and pulses `done`.
- **CLEAR:**
  - Writes 0 to addresses 0..`SIZE`-1, one address per cycle.
  - After the write to `SIZE`-1, the block returns to IDLE and pulses `done` on the next cycle.
- **Commands while busy:** `start` and `clr` are ignored. They are not queued.
- **Reset:**
  - Outputs: `do`=0, `do_valid`=0, `do_last`=0, `busy`=0, `done`=0.
  - State goes to IDLE; counters and the skid buffer are cleared.
  - Array contents are not reset.
  - Reset asserted mid-burst or mid-clear aborts immediately with no `done`. A partially cleared array stays partially cleared.

## Timing
- **`start`/`clr` accept:** the command is accepted at edge 0. `busy`=1 from edge 0.
- **Burst, `do_ready` held high:**
  - The first read issues in cycle 1.
  - `do_valid`=1 from cycle 2, with one word per cycle.
  - The last word appears in cycle `len`+1.
  - `done` pulses in cycle `len`+2, together with `busy`=0.
- **Sustained throughput:** 1 word/cycle while `do_ready`=1. Deasserting `do_ready` loses and duplicates no word.
- **Back-to-back bursts:** the minimum gap is 1 cycle. `start` is accepted in the cycle `done` is high.
- **Clear timing:** a clear takes `SIZE` cycles. `done` pulses in cycle `SIZE`+1.
- **`done` for `len`=0:** pulses 1 cycle after `start`, and `busy` stays 0.

## Test plan
- **Write then burst:**
  - Stimulus: write addresses 1..4 with 0xF0, 0x0F, 0xAA, 0x55, then `start` with `base_addr`=1, `len`=4, `do_ready`=1.
  - Required: `do` = F0, 0F, AA, 55 on consecutive cycles 2..5; `do_last` on 55; `done` in cycle 6.
- **Backpressure:**
  - Stimulus: same burst with `do_ready` toggled 1,0,0,1,0,1,1.
  - Required: exactly 4 transfers in order, and `do` stable whenever `do_valid`=1 and `do_ready`=0.
- **Wrap-around:**
  - Stimulus: write 0x11 @1022, 0x22 @1023, 0x33 @0, then `start` with `base_addr`=1022, `len`=3.
  - Required: 11, 22, 33; `do_last` on 33.
- **Read-during-write:**
  - Stimulus: in the cycle the read of address 5 (old value 0x01) issues, write 0x99 to address 5.
  - Required: the stream returns 0x01; a later burst returns 0x99.
- **Clear and ignored commands:**
  - Stimulus: `clr`, with `start` and `we` asserted mid-clear.
  - Required: neither `start` nor `we` has any effect; `done` in cycle 1025; a full burst then returns all zeros.
- **Reset mid-burst and `len`=0:**
  - Stimulus: drop `rst_n` during a `len`=8 burst.
  - Required: all outputs 0 immediately and no `done`.
  - Then `start` with `len`=0: `done` pulses 1 cycle later with no `do_valid`.
